// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared bus, pipeline and control types for the memory stage
package memory_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memsext;
        msize_t msize;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        ctl_t        ctl;
        logic [63:0] aluout;
        logic [63:0] rd2;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        ctl_t        ctl;
        logic [63:0] aluout;
        logic [63:0] readdata;
    } memory_data_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] off, input msize_t size);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic memory_data_t to_mem(input execute_data_t e, input logic [63:0] rdata,
                                            input logic vld);
        memory_data_t m;
        m.valid     = vld;
        m.pc        = e.pc;
        m.raw_instr = e.raw_instr;
        m.dst       = e.dst;
        m.ra1       = e.ra1;
        m.ra2       = e.ra2;
        m.ctl       = e.ctl;
        m.aluout    = e.aluout;
        m.readdata  = rdata;
        return m;
    endfunction

endpackage

// File: rtl/memory_memalign.sv
// rtl/memory_memalign.sv - byte-lane strobe/data placement and load extraction
module memalign
    import memory_pkg::*;
(
    input  logic [2:0]  offset_i,
    input  msize_t      size_i,
    input  logic        sext_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);

    logic [7:0]  lane_mask;
    logic [63:0] shifted;

    always_comb begin
        lane_mask = 8'h00;
        rdata_o   = 64'd0;
        shifted   = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            MSIZE1: begin
                lane_mask = 8'h01;
                rdata_o   = {{56{sext_i & shifted[7]}}, shifted[7:0]};
            end
            MSIZE2: begin
                lane_mask = 8'h03;
                rdata_o   = {{48{sext_i & shifted[15]}}, shifted[15:0]};
            end
            MSIZE4: begin
                lane_mask = 8'h0F;
                rdata_o   = {{32{sext_i & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                lane_mask = 8'hFF;
                rdata_o   = shifted;
            end
        endcase
        strobe_o = lane_mask << offset_i;
        wdata_o  = wdata_i << {offset_i, 3'b000};
    end

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - memory pipeline stage: issues data-bus requests and registers the M/W result
module memory
    import memory_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          flushM,
    output logic          stallM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          misalignM
);

    state_t        state_q, state_d;
    execute_data_t req_q, req_d;
    logic          flushed_q, flushed_d;
    memory_data_t  dataM_q, dataM_d;
    logic          misalign_q, misalign_d;

    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] load_data;
    logic        is_mem_e;
    logic        mis_e;
    logic        unused_ok;

    assign unused_ok = dresp.addr_ok ^ req_q.valid;

    memalign u_align (
        .offset_i (req_q.aluout[2:0]),
        .size_i   (req_q.ctl.msize),
        .sext_i   (req_q.ctl.memsext),
        .wdata_i  (req_q.rd2),
        .rdata_i  (dresp.data),
        .strobe_o (strobe),
        .wdata_o  (wdata),
        .rdata_o  (load_data)
    );

    assign is_mem_e = dataE.ctl.memread | dataE.ctl.memwrite;
    assign mis_e    = is_misaligned(dataE.aluout[2:0], dataE.ctl.msize);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        flushed_d     = flushed_q;
        dataM_d       = dataM_q;
        dataM_d.valid = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dataE.valid && !flushM) begin
                    if (is_mem_e && !mis_e) begin
                        req_d     = dataE;
                        flushed_d = 1'b0;
                        state_d   = S_WAIT;
                    end else begin
                        dataM_d    = to_mem(dataE, 64'd0, 1'b1);
                        misalign_d = is_mem_e;
                    end
                end
            end
            default: begin
                // A flush seen at any point of the wait still lets the bus finish but kills the result.
                if (flushM) flushed_d = 1'b1;
                if (dresp.data_ok) begin
                    dataM_d = to_mem(req_q, req_q.ctl.memread ? load_data : 64'd0,
                                     !(flushed_q || flushM));
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        stallM      = (state_q == S_WAIT);
        dreq.valid  = (state_q == S_WAIT);
        dreq.addr   = req_q.aluout;
        dreq.size   = req_q.ctl.msize;
        dreq.strobe = strobe;
        dreq.data   = wdata;
    end

    assign dataM     = dataM_q;
    assign misalignM = misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            flushed_q  <= 1'b0;
            dataM_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            flushed_q  <= flushed_d;
            dataM_q    <= dataM_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for the memory stage
module tb_memory;
    import memory_pkg::*;

    logic          clk;
    logic          reset;
    execute_data_t dataE;
    logic          flushM;
    logic          stallM;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          misalignM;

    int n_cmp;
    int n_err;

    memory dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .flushM    (flushM),
        .stallM    (stallM),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM     (dataM),
        .misalignM (misalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic execute_data_t mk(input logic [63:0] addr, input logic [63:0] rd2,
                                         input logic rd, input logic wr, input logic sext,
                                         input msize_t sz);
        execute_data_t e;
        e              = '0;
        e.valid        = 1'b1;
        e.pc           = 64'h8000_0000 + addr;
        e.raw_instr    = 32'h0000_0013;
        e.dst          = 5'd3;
        e.ra1          = 5'd1;
        e.ra2          = 5'd2;
        e.ctl.regwrite = rd | !wr;
        e.ctl.memread  = rd;
        e.ctl.memwrite = wr;
        e.ctl.memsext  = sext;
        e.ctl.msize    = sz;
        e.aluout       = addr;
        e.rd2          = rd2;
        return e;
    endfunction

    task automatic test_reset();
        reset  = 1'b0;
        dataE  = '0;
        flushM = 1'b0;
        dresp  = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stallM); end
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL reset_dreq got=%b exp=0", dreq.valid); end
        n_cmp++; if (dataM !== memory_data_t'(0)) begin n_err++; $display("FAIL reset_dataM got=%h exp=0", dataM); end
        n_cmp++; if (misalignM !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", misalignM); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        dataE = mk(64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, MSIZE8);
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b exp=0", stallM); end
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dataM.valid !== 1'b1) begin n_err++; $display("FAIL alu_valid got=%b exp=1", dataM.valid); end
        n_cmp++; if (dataM.aluout !== 64'h1234) begin n_err++; $display("FAIL alu_aluout got=%h exp=1234", dataM.aluout); end
        n_cmp++; if (dataM.readdata !== 64'h0) begin n_err++; $display("FAIL alu_readdata got=%h exp=0", dataM.readdata); end
        n_cmp++; if (stallM !== 1'b0 || dreq.valid !== 1'b0) begin n_err++; $display("FAIL alu_nobus got=%b%b exp=00", stallM, dreq.valid); end
        @(negedge clk);
        n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL alu_pulse got=%b exp=0", dataM.valid); end
    endtask

    task automatic test_lb_wait();
        dbus_req_t first;
        dataE = mk(64'h1003, 64'h0, 1'b1, 1'b0, 1'b1, MSIZE1);
        @(negedge clk);
        dataE = '0;
        first = dreq;
        n_cmp++; if (dreq.valid !== 1'b1) begin n_err++; $display("FAIL lb_dreq_valid got=%b exp=1", dreq.valid); end
        n_cmp++; if (dreq.strobe !== 8'h08) begin n_err++; $display("FAIL lb_strobe got=%h exp=08", dreq.strobe); end
        n_cmp++; if (dreq.addr !== 64'h1003 || dreq.size !== MSIZE1) begin n_err++; $display("FAIL lb_addr_size got=%h/%0d exp=1003/0", dreq.addr, dreq.size); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (dreq !== first || stallM !== 1'b1) begin n_err++; $display("FAIL lb_hold cyc=%0d got=%h stall=%b exp=%h stall=1", i, dreq, stallM, first); end
            n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL lb_early_valid cyc=%0d got=%b exp=0", i, dataM.valid); end
            if (i == 2) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = 64'h0000_0000_8000_0000;
            end
        end
        @(negedge clk);
        dresp = '0;
        n_cmp++; if (dataM.valid !== 1'b1) begin n_err++; $display("FAIL lb_valid got=%b exp=1", dataM.valid); end
        n_cmp++; if (dataM.readdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_readdata got=%h exp=ffffffffffffff80", dataM.readdata); end
        n_cmp++; if (dreq.valid !== 1'b0 || stallM !== 1'b0) begin n_err++; $display("FAIL lb_release got=%b%b exp=00", dreq.valid, stallM); end
        @(negedge clk);
    endtask

    task automatic test_sh();
        dataE = mk(64'h2006, 64'hABCD, 1'b0, 1'b1, 1'b0, MSIZE2);
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dreq.size !== MSIZE2) begin n_err++; $display("FAIL sh_size got=%0d exp=1", dreq.size); end
        n_cmp++; if (dreq.strobe !== 8'hC0) begin n_err++; $display("FAIL sh_strobe got=%h exp=c0", dreq.strobe); end
        n_cmp++; if (dreq.data[63:48] !== 16'hABCD) begin n_err++; $display("FAIL sh_data got=%h exp=abcd", dreq.data[63:48]); end
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dresp = '0;
        n_cmp++; if (dataM.valid !== 1'b1 || dataM.readdata !== 64'h0) begin n_err++; $display("FAIL sh_done got=%b/%h exp=1/0", dataM.valid, dataM.readdata); end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        dataE = mk(64'h1002, 64'h0, 1'b1, 1'b0, 1'b1, MSIZE4);
        #1;
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL mis_nodreq0 got=%b exp=0", dreq.valid); end
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dreq.valid !== 1'b0 || stallM !== 1'b0) begin n_err++; $display("FAIL mis_nodreq got=%b%b exp=00", dreq.valid, stallM); end
        n_cmp++; if (dataM.valid !== 1'b1 || misalignM !== 1'b1) begin n_err++; $display("FAIL mis_flag got=%b%b exp=11", dataM.valid, misalignM); end
        n_cmp++; if (dataM.readdata !== 64'h0) begin n_err++; $display("FAIL mis_readdata got=%h exp=0", dataM.readdata); end
        @(negedge clk);
        n_cmp++; if (misalignM !== 1'b0) begin n_err++; $display("FAIL mis_pulse got=%b exp=0", misalignM); end
    endtask

    task automatic test_flush_wait();
        dataE = mk(64'h3000, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE8);
        @(negedge clk);
        dataE  = mk(64'h55, 64'h0, 1'b0, 1'b0, 1'b0, MSIZE8);
        flushM = 1'b1;
        @(negedge clk);
        flushM = 1'b0;
        n_cmp++; if (dreq.valid !== 1'b1 || stallM !== 1'b1) begin n_err++; $display("FAIL flush_hold got=%b%b exp=11", dreq.valid, stallM); end
        dresp.data_ok = 1'b1;
        dresp.addr_ok = 1'b1;
        dresp.data    = 64'h1122_3344_5566_7788;
        @(negedge clk);
        dresp = '0;
        n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL flush_killed got=%b exp=0", dataM.valid); end
        n_cmp++; if (stallM !== 1'b0 || dreq.valid !== 1'b0) begin n_err++; $display("FAIL flush_idle got=%b%b exp=00", stallM, dreq.valid); end
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dataM.valid !== 1'b1 || dataM.aluout !== 64'h55) begin n_err++; $display("FAIL flush_next got=%b/%h exp=1/55", dataM.valid, dataM.aluout); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        dataE = mk(64'h10, 64'h77, 1'b0, 1'b1, 1'b0, MSIZE1);
        @(negedge clk);
        dataE         = mk(64'h11, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE1);
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        @(negedge clk);
        dresp = '0;
        n_cmp++; if (dreq.valid !== 1'b0 || dataM.valid !== 1'b1) begin n_err++; $display("FAIL b2b_gap got=%b/%b exp=0/1", dreq.valid, dataM.valid); end
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dreq.valid !== 1'b1 || dreq.addr !== 64'h11 || dreq.strobe !== 8'h02) begin n_err++; $display("FAIL b2b_second got=%b/%h/%h exp=1/11/02", dreq.valid, dreq.addr, dreq.strobe); end
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0000_0000_0000_F100;
        @(negedge clk);
        dresp = '0;
        n_cmp++; if (dataM.valid !== 1'b1 || dataM.readdata !== 64'hF1) begin n_err++; $display("FAIL b2b_zext got=%b/%h exp=1/f1", dataM.valid, dataM.readdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        dataE = mk(64'h4000, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE8);
        @(negedge clk);
        dataE = '0;
        n_cmp++; if (dreq.valid !== 1'b1) begin n_err++; $display("FAIL rst_wait_entry got=%b exp=1", dreq.valid); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (dreq.valid !== 1'b0 || stallM !== 1'b0) begin n_err++; $display("FAIL rst_async got=%b%b exp=00", dreq.valid, stallM); end
        n_cmp++; if (dataM !== memory_data_t'(0)) begin n_err++; $display("FAIL rst_dataM got=%h exp=0", dataM); end
        @(negedge clk);
        reset         = 1'b1;
        dresp.data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dresp = '0;
            n_cmp++; if (dataM.valid !== 1'b0 || dreq.valid !== 1'b0) begin n_err++; $display("FAIL rst_no_complete cyc=%0d got=%b%b exp=00", i, dataM.valid, dreq.valid); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_alu();
        test_lb_wait();
        test_sh();
        test_misalign();
        test_flush_wait();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
